// File: rtl/smc_feedback_frontend_if.sv
// Bundle of the measurement front-end signals between the encoder/reference side and the
// sliding-mode controller side.
//   Inputs to the front end : enc_a, enc_b (raw encoder, async), theta_ref, theta_dot_ref
//                             (Q21.10), u_in (previous controller output), clr_err.
//   Outputs of the front end: theta_pos, theta_dot, theta_e, theta_dote, u_t (all 32-bit),
//                             sample_valid (1-cycle strobe), enc_err (sticky).
// master: the side that drives the inputs and consumes the outputs.
// slave : the front end itself.
interface smc_feedback_frontend_if;
   logic        enc_a;
   logic        enc_b;
   logic [31:0] theta_ref;
   logic [31:0] theta_dot_ref;
   logic [15:0] u_in;
   logic        clr_err;
   logic [31:0] theta_pos;
   logic [31:0] theta_dot;
   logic [31:0] theta_e;
   logic [31:0] theta_dote;
   logic [31:0] u_t;
   logic        sample_valid;
   logic        enc_err;

   modport master (
      output enc_a, enc_b, theta_ref, theta_dot_ref, u_in, clr_err,
      input  theta_pos, theta_dot, theta_e, theta_dote, u_t, sample_valid, enc_err
   );

   modport slave (
      input  enc_a, enc_b, theta_ref, theta_dot_ref, u_in, clr_err,
      output theta_pos, theta_dot, theta_e, theta_dote, u_t, sample_valid, enc_err
   );
endinterface

// File: rtl/smc_feedback_frontend.sv
// Measurement front end for the sliding-mode controller.
// Decodes a x4 quadrature encoder into a 32-bit wrapping position count, samples it once per
// control period, differentiates to velocity and forms tracking errors against the references.
// All data outputs are signed Q21.10, registered, and qualified by sample_valid.
// Ports:
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   fe_io : front-end bundle (slave side), see smc_feedback_frontend_if
module smc_feedback_frontend #(
   parameter int unsigned SAMPLE_DIV = 10000,
   parameter int unsigned SAMPLE_HZ  = 1000,
   parameter int unsigned FRAC       = 10,
   parameter int unsigned U_SHIFT    = 16
) (
   input logic                    clk,
   input logic                    rst,
   smc_feedback_frontend_if.slave fe_io
);

   localparam int unsigned TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   // Clamp a 64-bit two's-complement value into 32 bits.
   function automatic logic [31:0] sat64(input logic [63:0] v);
      if (v[63:31] == {33{v[63]}}) return v[31:0];
      return v[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
   endfunction

   // Clamp a 33-bit two's-complement value into 32 bits.
   function automatic logic [31:0] sat33(input logic [32:0] v);
      if (v[32] == v[31]) return v[31:0];
      return v[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
   endfunction

   // ------------------------------------------------------------------------------------------
   // Encoder synchroniser and x4 decode
   // ------------------------------------------------------------------------------------------
   logic        a_meta_q, b_meta_q, a_sync_q, b_sync_q;
   logic [1:0]  ab_prev_q;
   logic [1:0]  ab_cur, idx_cur, idx_prev, idx_diff;
   logic [31:0] pos_cnt_q, pos_cnt_d;
   logic        enc_err_q, enc_err_d;
   logic        illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_meta_q  <= 1'b0;
         b_meta_q  <= 1'b0;
         a_sync_q  <= 1'b0;
         b_sync_q  <= 1'b0;
         ab_prev_q <= 2'b00;
         pos_cnt_q <= '0;
         enc_err_q <= 1'b0;
      end else begin
         a_meta_q  <= fe_io.enc_a;
         b_meta_q  <= fe_io.enc_b;
         a_sync_q  <= a_meta_q;
         b_sync_q  <= b_meta_q;
         ab_prev_q <= ab_cur;
         pos_cnt_q <= pos_cnt_d;
         enc_err_q <= enc_err_d;
      end
   end

   // Map the Gray sequence 00,01,11,10 onto 0..3 so a step is a modulo-4 difference.
   always_comb begin
      ab_cur    = {a_sync_q, b_sync_q};
      idx_cur   = {ab_cur[1], ab_cur[1] ^ ab_cur[0]};
      idx_prev  = {ab_prev_q[1], ab_prev_q[1] ^ ab_prev_q[0]};
      idx_diff  = idx_cur - idx_prev;
      pos_cnt_d = pos_cnt_q;
      illegal   = 1'b0;
      case (idx_diff)
         2'd1:    pos_cnt_d = pos_cnt_q + 32'd1;
         2'd3:    pos_cnt_d = pos_cnt_q - 32'd1;
         2'd2:    illegal = 1'b1;
         default: pos_cnt_d = pos_cnt_q;
      endcase
      // A fresh illegal transition beats a simultaneous clear.
      enc_err_d = illegal | (enc_err_q & ~fe_io.clr_err);
   end

   // ------------------------------------------------------------------------------------------
   // Control-period timer
   // ------------------------------------------------------------------------------------------
   logic [TW-1:0] timer_q, timer_d;
   logic          tick;

   always_comb begin
      tick    = (timer_q == TW'(SAMPLE_DIV - 1));
      timer_d = tick ? '0 : timer_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) timer_q <= '0;
      else     timer_q <= timer_d;
   end

   // ------------------------------------------------------------------------------------------
   // Sample pipeline. S1 on the tick edge, S2 and S3 on the following two edges. The stages
   // never overlap, so S2/S3 read S1's latched references directly.
   // ------------------------------------------------------------------------------------------
   logic [31:0] pos_s_q, pos_prev_q, delta_q, ref_s_q, dref_s_q;
   logic [15:0] u_s_q;
   logic        first_s_q, primed_q;
   logic        s1_vld_q, s2_vld_q;
   logic [31:0] pos_fx_q, vel_fx_q;
   logic [31:0] pos_fx_d, vel_fx_d;
   logic [63:0] pos_ext, vel_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_s_q    <= '0;
         pos_prev_q <= '0;
         delta_q    <= '0;
         ref_s_q    <= '0;
         dref_s_q   <= '0;
         u_s_q      <= '0;
         first_s_q  <= 1'b0;
         primed_q   <= 1'b0;
         s1_vld_q   <= 1'b0;
         s2_vld_q   <= 1'b0;
         pos_fx_q   <= '0;
         vel_fx_q   <= '0;
      end else begin
         s1_vld_q <= tick;
         s2_vld_q <= s1_vld_q;
         if (tick) begin
            // pos_cnt_q is the count before this cycle's decode update.
            pos_s_q    <= pos_cnt_q;
            delta_q    <= pos_cnt_q - pos_prev_q;
            pos_prev_q <= pos_cnt_q;
            ref_s_q    <= fe_io.theta_ref;
            dref_s_q   <= fe_io.theta_dot_ref;
            u_s_q      <= fe_io.u_in;
            first_s_q  <= ~primed_q;
            primed_q   <= 1'b1;
         end
         if (s1_vld_q) begin
            pos_fx_q <= pos_fx_d;
            vel_fx_q <= vel_fx_d;
         end
      end
   end

   // Low 64 bits of the products are exact two's complement, so unsigned arithmetic suffices.
   always_comb begin
      pos_ext  = {{32{pos_s_q[31]}}, pos_s_q} << FRAC;
      vel_ext  = ({{32{delta_q[31]}}, delta_q} * 64'(SAMPLE_HZ)) << FRAC;
      pos_fx_d = sat64(pos_ext);
      // No valid previous sample exists for the first period after reset.
      vel_fx_d = first_s_q ? 32'h0 : sat64(vel_ext);
   end

   // ------------------------------------------------------------------------------------------
   // S3: error terms and output registers
   // ------------------------------------------------------------------------------------------
   logic [31:0] theta_pos_q, theta_dot_q, theta_e_q, theta_dote_q, u_t_q;
   logic [31:0] theta_e_d, theta_dote_d, u_t_d;
   logic [32:0] e_ext, de_ext;
   logic        sample_valid_q;

   always_comb begin
      e_ext        = {ref_s_q[31], ref_s_q} - {pos_fx_q[31], pos_fx_q};
      de_ext       = {dref_s_q[31], dref_s_q} - {vel_fx_q[31], vel_fx_q};
      theta_e_d    = sat33(e_ext);
      theta_dote_d = sat33(de_ext);
      u_t_d        = {{16{u_s_q[15]}}, u_s_q} << U_SHIFT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         theta_pos_q    <= '0;
         theta_dot_q    <= '0;
         theta_e_q      <= '0;
         theta_dote_q   <= '0;
         u_t_q          <= '0;
         sample_valid_q <= 1'b0;
      end else begin
         sample_valid_q <= s2_vld_q;
         if (s2_vld_q) begin
            theta_pos_q  <= pos_fx_q;
            theta_dot_q  <= vel_fx_q;
            theta_e_q    <= theta_e_d;
            theta_dote_q <= theta_dote_d;
            u_t_q        <= u_t_d;
         end
      end
   end

   assign fe_io.theta_pos    = theta_pos_q;
   assign fe_io.theta_dot    = theta_dot_q;
   assign fe_io.theta_e      = theta_e_q;
   assign fe_io.theta_dote   = theta_dote_q;
   assign fe_io.u_t          = u_t_q;
   assign fe_io.sample_valid = sample_valid_q;
   assign fe_io.enc_err      = enc_err_q;

endmodule
